// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester id and latched request.
// Round-robin arbitration is enabled by defining DATA_MEM_ARB_RR_EN.
package mem_arb_pkg;

    typedef logic [31:0] Addr;
    typedef logic [31:0] Data;
    typedef logic        Bool;
    typedef logic        ReqId;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } ArbState;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef struct packed {
        Addr  addr;
        Data  wdata;
        Bool  we;
        ReqId id;
    } MemReq;

    function automatic Bool is_aligned(input Addr addr);
        return (addr[1:0] & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way grant. With DATA_MEM_ARB_RR_EN defined, contention goes to the
// requester not granted last; otherwise requester 0 always wins contention.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_valid_i,
`ifdef DATA_MEM_ARB_RR_EN
    input  ReqId       last_grant_i,
`endif
    output logic       grant_valid_o,
    output ReqId       grant_id_o
);

    // NOTE: every output gets a default before the branches, so no latch is inferred.
    always_comb begin
        grant_valid_o = |req_valid_i;
        grant_id_o    = 1'b0;
        if (req_valid_i == 2'b11) begin
`ifdef DATA_MEM_ARB_RR_EN
            grant_id_o = ~last_grant_i;
`else
            grant_id_o = 1'b0;
`endif
        end else if (req_valid_i[1]) begin
            grant_id_o = 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-ported data memory.
// Define DATA_MEM_ARB_RR_EN for round-robin contention; default is fixed priority to requester 0.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    input  logic [1:0]  req_we,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_idx,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    // Keeps only the word-index bits; higher address bits wrap within the memory.
    localparam logic [31:0] IDX_MASK = ((32'd1 << IDX_W) - 32'd1) << 2;

    ArbState     state_q;
    MemReq       req_q;
    logic [1:0]  rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic grant_valid;
    ReqId grant_id;
    logic accept;
    logic in_access;
    logic req_aligned;

`ifdef DATA_MEM_ARB_RR_EN
    ReqId last_grant_q;
`endif

    rr_arbiter2 u_arb (
        .req_valid_i   (req_valid),
`ifdef DATA_MEM_ARB_RR_EN
        .last_grant_i  (last_grant_q),
`endif
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    // Memory-side and ready outputs are gated by reset_n so a reset cycle drives nothing.
    assign accept      = reset_n && (state_q != ACCESS) && grant_valid;
    assign in_access   = reset_n && (state_q == ACCESS);
    assign req_aligned = is_aligned(req_q.addr);

    assign req_ready        = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign mem_idx          = in_access ? (req_q.addr & IDX_MASK) : '0;
    assign mem_write_data   = in_access ? req_q.wdata : '0;
    assign mem_write_enable = in_access && req_q.we && req_aligned;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef DATA_MEM_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            rsp_valid_q <= 2'b00;
            case (state_q)
                IDLE, RESP: begin
                    if (grant_valid) begin
                        req_q <= '{addr:  grant_id ? req_addr1  : req_addr0,
                                   wdata: grant_id ? req_wdata1 : req_wdata0,
                                   we:    req_we[grant_id],
                                   id:    grant_id};
`ifdef DATA_MEM_ARB_RR_EN
                        last_grant_q <= grant_id;
`endif
                        state_q <= ACCESS;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    rsp_valid_q <= req_q.id ? 2'b10 : 2'b01;
                    rsp_rdata_q <= (!req_q.we && req_aligned) ? mem_read_data : '0;
                    rsp_err_q   <= !req_aligned;
                    state_q     <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
